cic_interp_multich: RTL and testbench

//  Parametrised N-channel CIC interpolator on a single clock. Channels are packed in one input word.

---
 rtl/cic_interp_pkg.sv | 35 +++
 rtl/cic_interp_lane.sv | 71 +++++++
 rtl/cic_interp_multich.sv | 110 +++++++++++
 tb/tb_cic_interp_multich.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_interp_pkg.sv
`default_nettype none
// ============================================================================
// cic_interp_pkg : width, gain-shift and saturation helpers for the CIC lanes
// Revision: 1.0
// ============================================================================
package cic_interp_pkg;

    function automatic int unsigned cic_w_int(input int unsigned data_w,
                                              input int unsigned nstg,
                                              input int unsigned r);
        return data_w + nstg * int'($clog2(r));
    endfunction

    // Shift that removes the R^(NSTG-1) DC gain of an interpolating CIC.
    function automatic int unsigned cic_gain_shift(input int unsigned nstg,
                                                   input int unsigned r);
        return (nstg - 1) * int'($clog2(r));
    endfunction

    function automatic logic signed [63:0] cic_saturate(input logic signed [63:0] v,
                                                        input int unsigned      data_w);
        logic signed [63:0] v_hi;
        logic signed [63:0] v_lo;
        v_hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        v_lo = -(64'sd1 <<< (data_w - 1));
        if (v > v_hi) begin
            return v_hi;
        end else if (v < v_lo) begin
            return v_lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_interp_lane.sv
`default_nettype none
// ============================================================================
// cic_interp_lane : one channel of the CIC interpolator (combs, integrators,
//                   gain shift and output saturation)
// Revision: 1.0
// ============================================================================
module cic_interp_lane
    import cic_interp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned R      = 8,
    parameter int unsigned NSTG   = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     load,
    input  logic                     clr_int,
    input  logic signed [DATA_W-1:0] comb_in,
    output logic signed [DATA_W-1:0] cic_out
);
    localparam int unsigned c_w_int = cic_w_int(DATA_W, NSTG, R);
    localparam int unsigned c_shift = cic_gain_shift(NSTG, R);

    logic signed [c_w_int-1:0] r_dly      [NSTG];
    logic signed [c_w_int-1:0] r_intg     [NSTG];
    logic signed [c_w_int-1:0] w_tap      [NSTG];
    logic signed [c_w_int-1:0] w_intg_nxt [NSTG];
    logic signed [c_w_int-1:0] w_shifted;

    // Whole comb and integrator cascades settle in one clock; the comb output
    // only feeds the integrators on phase-0 ticks (zero stuffing otherwise).
    always_comb begin
        logic signed [c_w_int-1:0] v_acc;
        v_acc = c_w_int'(comb_in);
        for (int k = 0; k < int'(NSTG); k++) begin
            w_tap[k] = v_acc;
            v_acc    = v_acc - r_dly[k];
        end
        if (!load) begin
            v_acc = '0;
        end
        for (int k = 0; k < int'(NSTG); k++) begin
            v_acc         = (clr_int ? '0 : r_intg[k]) + v_acc;
            w_intg_nxt[k] = v_acc;
        end
    end

    assign w_shifted = w_intg_nxt[NSTG-1] >>> c_shift;
    assign cic_out   = DATA_W'(cic_saturate(64'(w_shifted), DATA_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                r_dly[k]  <= '0;
                r_intg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NSTG); k++) begin
                if (load) begin
                    r_dly[k] <= w_tap[k];
                end
                if (tick) begin
                    r_intg[k] <= w_intg_nxt[k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_interp_multich.sv
`default_nettype none
// ============================================================================
// cic_interp_multich : N-channel single-clock CIC interpolator with input
//                      handshake, zero-order-hold mode and underflow flag
// Revision: 1.0
// ============================================================================
module cic_interp_multich
    import cic_interp_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned R      = 8,
    parameter int unsigned NSTG   = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    out_tick,
    input  logic                    mode,
    input  logic [NCH*DATA_W-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NCH*DATA_W-1:0]   out_data,
    output logic                    out_valid,
    output logic                    underflow
);
    localparam int unsigned c_frame_w = NCH * DATA_W;
    localparam int unsigned c_ph_w    = $clog2(R);

    logic [c_ph_w-1:0]    r_phase;
    logic                 r_buf_full;
    logic                 r_mode;
    logic [c_frame_w-1:0] r_buf;
    logic [c_frame_w-1:0] r_hold;
    logic [c_frame_w-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_underflow;

    logic                 w_phase0;
    logic                 w_consume;
    logic                 w_accept;
    logic                 w_mode_eff;
    logic                 w_clr_int;
    logic [c_frame_w-1:0] w_hold_nxt;
    logic [c_frame_w-1:0] w_comb_frame;
    logic [c_frame_w-1:0] w_cic_frame;

    assign w_phase0     = out_tick && (r_phase == '0);
    assign w_consume    = w_phase0 && r_buf_full;
    assign w_accept     = in_valid && !r_buf_full;
    assign w_mode_eff   = w_phase0 ? mode : r_mode;
    assign w_clr_int    = w_phase0 && (mode != r_mode);
    assign w_hold_nxt   = w_consume ? r_buf : r_hold;
    assign w_comb_frame = w_consume ? r_buf : '0;

    // ch0 sits in the MSBs of every packed frame.
    generate
        for (genvar g = 0; g < int'(NCH); g++) begin : g_lane
            cic_interp_lane #(
                .DATA_W (DATA_W),
                .R      (R),
                .NSTG   (NSTG)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .tick    (out_tick),
                .load    (w_phase0),
                .clr_int (w_clr_int),
                .comb_in (w_comb_frame[(int'(NCH)-g)*int'(DATA_W)-1 -: DATA_W]),
                .cic_out (w_cic_frame[(int'(NCH)-g)*int'(DATA_W)-1 -: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase     <= '0;
            r_buf_full  <= 1'b0;
            r_mode      <= 1'b0;
            r_buf       <= '0;
            r_hold      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf      <= in_data;
                r_buf_full <= 1'b1;
            end else if (w_consume) begin
                r_buf_full <= 1'b0;
            end
            if (out_tick) begin
                r_phase    <= (r_phase == c_ph_w'(R - 1)) ? '0 : r_phase + 1'b1;
                r_out_data <= w_mode_eff ? w_hold_nxt : w_cic_frame;
            end
            if (w_phase0) begin
                r_mode <= mode;
            end
            r_hold      <= w_hold_nxt;
            r_out_valid <= out_tick;
            r_underflow <= w_phase0 && !r_buf_full;
        end
    end

    assign in_ready  = !r_buf_full;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_cic_interp_multich.sv
`default_nettype none
// ============================================================================
// tb_cic_interp_multich : randomized bench against a polynomial/cumulative-sum
//                         reference of the CIC interpolator
// Revision: 1.0
// ============================================================================
module tb_cic_interp_multich;
    localparam int NCH     = 2;
    localparam int DATA_W  = 16;
    localparam int R       = 8;
    localparam int NSTG    = 3;
    localparam int LOGR    = $clog2(R);
    localparam int SHIFT   = (NSTG - 1) * LOGR;
    localparam int W_INT   = DATA_W + NSTG * LOGR;
    localparam int FW      = NCH * DATA_W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          out_tick;
    logic          mode;
    logic [FW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] out_data;
    logic          out_valid;
    logic          underflow;

    always #5 clk = ~clk;

    cic_interp_multich #(
        .NCH    (NCH),
        .DATA_W (DATA_W),
        .R      (R),
        .NSTG   (NSTG)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .out_tick  (out_tick),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underflow (underflow)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_acc   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: low-rate input history, integrator sums, buffer.
    longint        m_x [NCH][NSTG+1];
    longint        m_s [NCH][NSTG];
    logic [FW-1:0] m_buf, m_hold, m_out;
    bit            m_full, m_mode, m_ov, m_uf;
    int            m_phase;
    longint        h [256];

    function automatic longint wrap_int(input longint v);
        longint span;
        longint r;
        span = longint'(1) <<< W_INT;
        r    = v & (span - 1);
        if (r >= span / 2) r = r - span;
        return r;
    endfunction

    function automatic longint binom(input int n, input int k);
        longint b = 1;
        for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
        return b;
    endfunction

    function automatic longint ch_of(input logic [FW-1:0] f, input int c);
        logic signed [DATA_W-1:0] v;
        v = f[(NCH-c)*DATA_W-1 -: DATA_W];
        return longint'(v);
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        int            sel;
        for (int c = 0; c < NCH; c++) begin
            sel = $urandom_range(0, 7);
            f[(NCH-c)*DATA_W-1 -: DATA_W] = (sel == 0) ? 16'h8000 :
                                            (sel == 1) ? 16'h7fff : DATA_W'($urandom);
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j <= NSTG; j++) m_x[c][j] = 0;
            for (int k = 0; k < NSTG; k++) m_s[c][k] = 0;
        end
        m_buf = '0; m_hold = '0; m_out = '0;
        m_full = 0; m_mode = 0; m_ov = 0; m_uf = 0; m_phase = 0;
    endtask

    task automatic step(input bit tk, input bit vld, input logic [FW-1:0] d, input bit md);
        bit            acc, p0;
        longint        u, y;
        logic [FW-1:0] cic;
        out_tick = tk; in_valid = vld; in_data = d; mode = md;
        if (vld && in_ready) n_acc++;
        acc  = vld && !m_full;
        m_ov = tk;
        m_uf = 0;
        cic  = '0;
        if (tk) begin
            p0 = (m_phase == 0);
            if (p0) begin
                if (md != m_mode) begin
                    for (int c = 0; c < NCH; c++)
                        for (int k = 0; k < NSTG; k++) m_s[c][k] = 0;
                    m_mode = md;
                end
                for (int c = 0; c < NCH; c++) begin
                    for (int j = NSTG; j > 0; j--) m_x[c][j] = m_x[c][j-1];
                    m_x[c][0] = m_full ? ch_of(m_buf, c) : 0;
                end
                if (m_full) m_hold = m_buf;
                else        m_uf = 1;
                m_full = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                u = 0;
                if (p0)
                    for (int j = 0; j <= NSTG; j++)
                        u += ((j % 2) ? -1 : 1) * binom(NSTG, j) * m_x[c][j];
                for (int k = 0; k < NSTG; k++)
                    m_s[c][k] = wrap_int(m_s[c][k] + ((k == 0) ? u : m_s[c][k-1]));
                y = m_s[c][NSTG-1] >>> SHIFT;
                if (y > 32767)  y = 32767;
                if (y < -32768) y = -32768;
                cic[(NCH-c)*DATA_W-1 -: DATA_W] = y[DATA_W-1:0];
            end
            m_out   = m_mode ? m_hold : cic;
            m_phase = (m_phase + 1) % R;
        end
        if (acc) begin
            m_full = 1;
            m_buf  = d;
        end
        @(posedge clk);
        #1;
        check_val("out_valid", out_valid, m_ov);
        check_val("underflow", underflow, m_uf);
        check_val("in_ready", in_ready, !m_full);
        check_val("out_data", out_data, m_out);
    endtask

    task automatic tick_pair(input bit vld, input logic [FW-1:0] d, input bit md);
        step(1, vld, d, md);
        step(0, vld, d, md);
    endtask

    task automatic do_reset();
        reset_n = 0; out_tick = 0; in_valid = 0; mode = 0; in_data = '0;
        #2;
        model_reset();
        check_val("rst_data", out_data, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_uf", underflow, 0);
        check_val("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    initial begin
        logic [FW-1:0] f, fa, fneg, fpos, zero;
        longint        got, sum, tmp [256];
        int            len, wrapped;
        bit            seen_pos, md, tk, last_tk;

        // Impulse response of one CIC: NSTG-fold convolution of an R-tap boxcar.
        for (int i = 0; i < 256; i++) h[i] = 0;
        h[0] = 1; len = 1;
        repeat (NSTG) begin
            for (int i = 0; i < 256; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) tmp[i+j] += h[i];
            for (int i = 0; i < 256; i++) h[i] = tmp[i];
            len += R - 1;
        end

        reset_n = 0; out_tick = 0; in_valid = 0; mode = 0; in_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        // DC gain is exactly unity once the filter has filled.
        f = {16'sd1000, -16'sd1000};
        step(0, 1, f, 0);
        for (int i = 0; i < (NSTG + 1) * R; i++) begin
            tick_pair(1, f, 0);
            if (i >= NSTG * R) check_val("dc_steady", out_data, f);
        end

        // Impulse on ch0.
        do_reset();
        f = '0; f[FW-1 -: DATA_W] = 16'd256; zero = '0; sum = 0;
        step(0, 1, f, 0);
        for (int n = 0; n < (NSTG + 1) * R; n++) begin
            tick_pair(1, zero, 0);
            got = ch_of(out_data, 0);
            check_val("impulse", got, (256 * h[n]) >>> SHIFT);
            sum += got;
        end
        check_val("impulse_sum", sum, (256 * (R ** NSTG)) >>> SHIFT);

        // Full-scale negative to full-scale positive step.
        do_reset();
        fneg = {NCH{16'h8000}}; fpos = {NCH{16'h7fff}};
        step(0, 1, fneg, 0);
        for (int i = 0; i < 4 * R; i++) tick_pair(1, fneg, 0);
        check_val("sat_low", out_data, fneg);
        wrapped = 0; seen_pos = 0;
        for (int i = 0; i < 5 * R; i++) begin
            tick_pair(1, fpos, 0);
            got = ch_of(out_data, 0);
            if (seen_pos && got < 0) wrapped++;
            if (got > 0) seen_pos = 1;
        end
        check_val("sat_no_wrap", wrapped, 0);
        check_val("sat_high", out_data, fpos);

        // ZOH with one starved phase-0 tick.
        do_reset();
        fa = rand_frame();
        step(0, 1, fa, 1);
        for (int i = 0; i < R; i++) begin
            tick_pair(1, fa, 1);
            check_val("zoh_hold", out_data, fa);
        end
        for (int i = 0; i < R; i++) tick_pair(0, rand_frame(), 1);
        step(1, 0, rand_frame(), 1);
        check_val("uf_pulse", underflow, 1);
        check_val("uf_ready", in_ready, 1);
        check_val("zoh_repeat", out_data, fa);
        step(0, 0, rand_frame(), 1);
        check_val("uf_once", underflow, 0);

        // Continuous in_valid: one accept per R ticks.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 4 * R; i++) tick_pair(1, rand_frame(), 0);
        check_val("hs_accepts", n_acc, 4);

        // Asynchronous reset right after the tick that moved phase to 3.
        do_reset();
        f = rand_frame();
        step(0, 1, f, 0);
        while (m_phase != 2) tick_pair(1, f, 0);
        step(1, 1, f, 0);
        reset_n = 0;
        #2;
        model_reset();
        check_val("mid_rst_data", out_data, 0);
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1;
        step(0, 0, f, 0);
        step(0, 0, f, 0);
        step(1, 0, f, 0);
        check_val("mid_rst_phase0", underflow, 1);

        // Random traffic with occasional mode switches.
        do_reset();
        md = 0; last_tk = 0;
        for (int i = 0; i < 1500; i++) begin
            tk = !last_tk && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) md = !md;
            step(tk, $urandom_range(0, 3) != 0, rand_frame(), md);
            last_tk = tk;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
